// File: rtl/dcache_wt.sv
// rtl/dcache_wt.sv - direct-mapped write-through no-allocate data cache
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache_wt #(
  parameter int         INDEX_BITS = 4,
  parameter int         MEM_LAT    = 1,
  parameter logic [2:0] LD_WORD    = 3'b010,
  parameter logic [1:0] ST_WORD    = 2'b11
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [14:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_ready,
  output logic        core_done,
  output logic [31:0] core_rdata,
  output logic [14:0] address,
  output logic [31:0] dmem_wdata,
  output logic [2:0]  load_control,
  output logic [1:0]  store_control,
  input  logic [31:0] dmem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
`endif
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 13 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, FILL, STORE, DONE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               core_ready_q, core_ready_d;
  logic               core_done_q, core_done_d;
  logic [31:0]        core_rdata_q, core_rdata_d;
  logic [14:0]        address_q, address_d;
  logic [31:0]        dmem_wdata_q, dmem_wdata_d;
  logic [1:0]         store_control_q, store_control_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [31:0]        data_q [LINES];

  logic [INDEX_BITS-1:0] req_idx, lat_idx;
  logic [TAG_W-1:0]      req_tag, lat_tag;
  logic                  req_hit, lat_hit;
  logic                  line_we;
  logic [31:0]           line_data_d;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^core_addr[1:0];

  assign req_idx = core_addr[INDEX_BITS+1:2];
  assign req_tag = core_addr[14:INDEX_BITS+2];
  assign lat_idx = address_q[INDEX_BITS+1:2];
  assign lat_tag = address_q[14:INDEX_BITS+2];
  assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign lat_hit = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;
`endif

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    core_ready_d    = core_ready_q;
    core_done_d     = core_done_q;
    core_rdata_d    = core_rdata_q;
    address_d       = address_q;
    dmem_wdata_d    = dmem_wdata_q;
    store_control_d = store_control_q;
    valid_d         = valid_q;
    line_we         = 1'b0;
    line_data_d     = dmem_rdata;
`ifdef DCACHE_STATS_EN
    hit_cnt_d       = hit_cnt_q;
    miss_cnt_d      = miss_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (core_req && core_ready_q) begin
          address_d    = {core_addr[14:2], 2'b00};
          core_ready_d = 1'b0;
          if (core_we) begin
            dmem_wdata_d    = core_wdata;
            store_control_d = ST_WORD;
            state_d         = STORE;
          end else if (req_hit) begin
            core_rdata_d = data_q[req_idx];
            core_done_d  = 1'b1;
            state_d      = DONE;
`ifdef DCACHE_STATS_EN
            if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
`endif
          end else begin
            cnt_d   = 4'(MEM_LAT);
            state_d = FILL;
`ifdef DCACHE_STATS_EN
            if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
`endif
          end
        end
      end
      FILL: begin
        // The count reaching 1 marks the last cycle the address has been held.
        if (cnt_q == 4'd1) begin
          line_we          = 1'b1;
          line_data_d      = dmem_rdata;
          valid_d[lat_idx] = 1'b1;
          core_rdata_d     = dmem_rdata;
          core_done_d      = 1'b1;
          state_d          = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      STORE: begin
        store_control_d = 2'b00;
        if (lat_hit) begin
          line_we     = 1'b1;
          line_data_d = dmem_wdata_q;
        end
        core_done_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        core_done_d  = 1'b0;
        core_ready_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q         <= IDLE;
      cnt_q           <= 4'd0;
      core_ready_q    <= 1'b1;
      core_done_q     <= 1'b0;
      core_rdata_q    <= 32'd0;
      address_q       <= 15'd0;
      dmem_wdata_q    <= 32'd0;
      store_control_q <= 2'b00;
      valid_q         <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      core_ready_q    <= core_ready_d;
      core_done_q     <= core_done_d;
      core_rdata_q    <= core_rdata_d;
      address_q       <= address_d;
      dmem_wdata_q    <= dmem_wdata_d;
      store_control_q <= store_control_d;
      valid_q         <= valid_d;
    end
  end

  // Tag/data contents need no reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (line_we) begin
      data_q[lat_idx] <= line_data_d;
      tag_q[lat_idx]  <= lat_tag;
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hit_cnt_q  <= 16'd0;
      miss_cnt_q <= 16'd0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

  assign core_ready    = core_ready_q;
  assign core_done     = core_done_q;
  assign core_rdata    = core_rdata_q;
  assign address       = address_q;
  assign dmem_wdata    = dmem_wdata_q;
  assign store_control = store_control_q;
  assign load_control  = LD_WORD;

endmodule

// File: doc/dcache_wt.md
# dcache_wt

Direct-mapped, write-through, no-write-allocate data cache sitting between the core's load/store stage and `data_mem`. It serves word loads from a small tag/data array. On a load miss it fills one word from `data_mem`. Every store is forwarded to `data_mem` using that module's `address` / `dmem_wdata` / `load_control` / `store_control` / `dmem_rdata` port set.

## Interface
Parameters:
- `INDEX_BITS`, 4: line index width; 2^INDEX_BITS one-word lines.
- `MEM_LAT`, 1: cycles `address` is held before `dmem_rdata` is sampled (1..15).
- `LD_WORD`, 3'b010: `load_control` code for a word read.
- `ST_WORD`, 2'b11: `store_control` code for a word write; 2'b00 = no store.

Ports:
- `clk` in 1: clock. One clock domain.
- `nrst` in 1: reset, asynchronous, active-low.
- `core_req` in 1: request valid.
- `core_we` in 1: 1 = store, 0 = load.
- `core_addr` in 15: byte address. Bits [1:0] are ignored, so all accesses are word-aligned.
- `core_wdata` in 32: store data.
- `core_ready` out 1: cache can accept a request.
- `core_done` out 1: one-cycle completion pulse.
- `core_rdata` out 32: load data, valid while `core_done` is high on a load.
- `address` out 15: memory byte address.
- `dmem_wdata` out 32: memory write data.
- `load_control` out 3: memory read code.
- `store_control` out 2: memory write code.
- `dmem_rdata` in 32: memory read data.

## Operation
Address split:
- Index = `core_addr[INDEX_BITS+1:2]`.
- Tag = `core_addr[14:INDEX_BITS+2]`.
- Each line holds a valid bit, the tag and 32 data bits.

FSM states: IDLE, FILL, STORE, DONE.
- **IDLE**
  - `core_ready` = 1.
  - Accept when `core_req` & `core_ready`. Latch `we`, `addr`, `wdata`.
  - Load hit → DONE, with `core_rdata` = line data.
  - Load miss → FILL, with the latency counter loaded to MEM_LAT.
  - Store → STORE.
- **FILL**
  - Drive `address` = latched addr and `load_control` = LD_WORD.
  - Decrement the counter each cycle.
  - In the cycle the counter reaches 1: sample `dmem_rdata`, write data/tag into the line, set valid, load `core_rdata`, then → DONE.
- **STORE**
  - For exactly one cycle, drive `address`, `dmem_wdata` = latched wdata and `store_control` = ST_WORD.
  - On a tag hit with valid set, update the line data in the same cycle.
  - On a miss the array is untouched (no allocate), including the case of same index with a different tag.
  - Then → DONE.
- **DONE**
  - `core_done` = 1 for one cycle, then → IDLE.

Memory-side defaults:
- Outside STORE, `store_control` = 2'b00.
- `load_control` = LD_WORD always. Reads are side-effect free.
- `address` holds the last latched address.

Other rules:
- A `core_req` raised while `core_ready` = 0 is ignored. The core must hold it until accepted.
- `core_rdata` holds its value until the next load completes.

## Timing
Request accepted at edge N:
- Load hit: `core_done` is high in cycle N+1, and `core_ready` returns in N+2.
- Load miss: FILL occupies N+1..N+MEM_LAT, and `core_done` is high in N+MEM_LAT+1.
- Store: `store_control` is ST_WORD in N+1, and `core_done` is high in N+2.
- Maximum throughput is one request per 2 cycles.

Reset values:
- State = IDLE and `core_ready` = 1.
- `core_done` = 0 and `core_rdata` = 0.
- `address` = 0, `dmem_wdata` = 0, `store_control` = 2'b00, `load_control` = LD_WORD.
- All valid bits = 0. Data/tag contents are don't-care.

Reset asserted mid-FILL or mid-STORE:
- Immediate return to IDLE.
- No `core_done`.
- No line written.
- `store_control` drops to 00 asynchronously.

## Configuration
- `DCACHE_STATS_EN` defined:
  - Adds outputs `hit_cnt` (out 16) and `miss_cnt` (out 16).
  - Both counters saturate at 16'hFFFF and are reset to 0.
  - A load hit increments `hit_cnt` on acceptance; a load miss increments `miss_cnt` on acceptance.
  - Stores are not counted.
- `DCACHE_STATS_EN` undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- Reset, then load 20: miss. `load_control` = 3'b010 and `address` = 20 during FILL. Preload the memory word at 20 = 55. `core_done` with `core_rdata` = 55 at N+2 (MEM_LAT = 1).
- Repeat load 20: hit. `core_done` at N+1 with `core_rdata` = 55, and `address` is not driven to a new value.
- Store 77 to 20 (valid line): `store_control` = 2'b11 and `dmem_wdata` = 77 for one cycle, `core_done` at N+2. A following load 20 hits with 77.
- Store 99 to 84 (same index as 20 with INDEX_BITS = 4, different tag): memory word 84 = 99. Load 20 still hits with 77, and load 84 misses.
- Assert `nrst` low during FILL with MEM_LAT = 3: no `core_done`, `core_ready` = 1 after release, and the next load 20 misses.
- With `DCACHE_STATS_EN`, run the sequence miss, hit, hit: `hit_cnt` = 2 and `miss_cnt` = 1.
